// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   serial_in      asynchronous UART line, idle high
//   data_out       head-of-FIFO byte (0 while empty)
//   data_out_valid FIFO non-empty
//   data_out_ready consumer accepts data_out this cycle
//   fifo_count     occupied entries
//   frame_error    one-cycle pulse: stop bit sampled low
//   overflow       one-cycle pulse: good byte dropped because FIFO full
//
// Each bit is sampled at its midpoint. START checks the start bit half a bit
// after the falling edge. Each later sample follows one full bit period after
// the previous sample.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic [7:0]                    data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          overflow
);

  localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int MID            = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchronizer. Both stages reset to the idle line level.
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let rx_s receive the previous rx_meta, which is what makes two stages.
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
    end
  end

  // Receiver FSM state
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             fe_next, ov_next;
  logic             push;

  // FIFO handshake
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop;
  logic             accept;

  assign data_out_valid = (fifo_count != '0);
  assign pop            = data_out_valid && data_out_ready;
  // A full FIFO still accepts a byte when its head leaves in the same cycle.
  assign accept         = (fifo_count < DEPTH_C) || pop;
  assign data_out       = data_out_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      bit_idx     <= bit_idx_next;
      shift       <= shift_next;
      frame_error <= fe_next;
      overflow    <= ov_next;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    fe_next      = 1'b0;
    ov_next      = 1'b0;
    push         = 1'b0;

    unique case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = S_START;
      end

      S_START: begin
        if (cnt == CNT_MID) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;            // glitch: line already back high
          end else begin
            state_next   = S_DATA;
            bit_idx_next = '0;
          end
        end
      end

      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};  // LSB arrives first
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = S_STOP;
        end
      end

      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
            if (accept) push    = 1'b1;
            else        ov_next = 1'b1;
          end else begin
            fe_next    = 1'b1;
            state_next = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // A held-low line reports one framing error, not a stream of frames.
        cnt_next = '0;
        if (rx_s) state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: byte storage has no reset. fifo_count decides what is valid, and data_out is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo at 5 clocks per bit with an 8-entry FIFO.
// The stimulus pushes expected bytes into a queue.
// A monitor on the falling clock edge pops the queue and compares it with every byte the consumer accepts.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 10_000_000;
  localparam int FIFO_DEPTH = 8;
  localparam int CPB        = 5;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        serial_in = 1'b1;
  logic                        data_out_ready = 1'b0;
  logic [7:0]                  data_out;
  logic                        data_out_valid;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        frame_error;
  logic                        overflow;

  uart_rx_fifo #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .fifo_count    (fifo_count),
    .frame_error   (frame_error),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks       = 0;
  int         errors       = 0;
  int         fe_seen      = 0;
  int         ov_seen      = 0;
  int         pops_seen    = 0;
  int         last_pop_cyc = 0;
  int         t_start      = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor. It samples on the falling edge, between the points where the stimulus changes inputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_error) fe_seen++;
      if (overflow)    ov_seen++;
      if (data_out_valid && data_out_ready) begin
        pops_seen++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no byte", data_out);
        end else begin
          check("pop_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame: start, data bits LSB first, stop, each held CPB clocks.
  // The task returns at the start of the cycle in which the DUT samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    t_start   = cyc;
    serial_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) tick();
    end
    serial_in = stop;
    repeat (CPB) tick();
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (pops_seen < n && k < 100) begin
      tick();
      k++;
    end
    check("pop_timeout", pops_seen, n);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_valid", {31'h0, data_out_valid}, 0);
    check("rst_count", {28'h0, fifo_count}, 0);
    check("rst_data", {24'h0, data_out}, 0);
    check("rst_fe", {31'h0, frame_error}, 0);
    check("rst_ov", {31'h0, overflow}, 0);
    rst = 1'b0;
    repeat (4) tick();

    // 1: a single byte with the consumer always ready.
    // Valid appears 51 cycles after the start bit is driven.
    data_out_ready = 1'b1;
    exp_q.push_back(8'h78);
    send_frame(8'h78, 1'b1);
    wait_pops(1);
    check("t1_latency", last_pop_cyc - t_start, 51);
    tick();
    check("t1_count", {28'h0, fifo_count}, 0);
    check("t1_no_fe", fe_seen, 0);
    check("t1_no_ov", ov_seen, 0);

    // 2: four back-to-back frames are buffered, then drained one per cycle.
    data_out_ready = 1'b0;
    exp_q.push_back(8'h78); send_frame(8'h78, 1'b1);
    exp_q.push_back(8'h79); send_frame(8'h79, 1'b1);
    exp_q.push_back(8'h7A); send_frame(8'h7A, 1'b1);
    exp_q.push_back(8'h0D); send_frame(8'h0D, 1'b1);
    repeat (2) tick();
    check("t2_count4", {28'h0, fifo_count}, 4);
    check("t2_head", {24'h0, data_out}, 32'h78);
    data_out_ready = 1'b1;
    repeat (3) tick();
    check("t2_count1", {28'h0, fifo_count}, 1);
    tick();
    check("t2_count0", {28'h0, fifo_count}, 0);
    check("t2_pops", pops_seen, 5);
    data_out_ready = 1'b0;

    // 3a: nine frames into a full FIFO. The ninth byte is dropped with one overflow pulse.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    repeat (2) tick();
    check("t3_count8", {28'h0, fifo_count}, 8);
    check("t3_ov_once", ov_seen, 1);
    data_out_ready = 1'b1;
    repeat (10) tick();
    data_out_ready = 1'b0;
    check("t3_drained", {28'h0, fifo_count}, 0);
    check("t3_q_empty", exp_q.size(), 0);

    // 3b: the same fill, with a pop in the ninth stop-sample cycle, accepts the ninth byte.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    exp_q.push_back(8'h08);
    send_frame(8'h08, 1'b1);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    tick();
    check("t3b_count8", {28'h0, fifo_count}, 8);
    check("t3b_no_new_ov", ov_seen, 1);
    data_out_ready = 1'b1;
    repeat (10) tick();
    check("t3b_drained", {28'h0, fifo_count}, 0);
    check("t3b_q_empty", exp_q.size(), 0);

    // 4: a bad stop bit followed by a long break gives exactly one frame error, then normal reception.
    send_frame(8'h55, 1'b0);
    repeat (30 * CPB) tick();
    check("t4_fe_once", fe_seen, 1);
    check("t4_nothing_pushed", {28'h0, fifo_count}, 0);
    serial_in = 1'b1;
    repeat (2 * CPB) tick();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_pops(23);
    check("t4_fe_still_one", fe_seen, 1);

    // 5: a one-cycle glitch is rejected, and the next frame is received intact.
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    repeat (3 * CPB) tick();
    check("t5_count", {28'h0, fifo_count}, 0);
    check("t5_no_fe", fe_seen, 1);
    check("t5_no_ov", ov_seen, 1);
    check("t5_no_pop", pops_seen, 23);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_pops(24);

    // 6: reset mid-frame with two queued bytes discards everything.
    data_out_ready = 1'b0;
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22); send_frame(8'h22, 1'b1);
    repeat (2) tick();
    check("t6_count2", {28'h0, fifo_count}, 2);
    serial_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      serial_in = (i == 0 || i == 3);  // 0x99 low nibble: 1,0,0,1
      repeat (CPB) tick();
    end
    serial_in = 1'b1;                  // bit 4 of 0x99
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_valid0", {31'h0, data_out_valid}, 0);
    check("t6_count0", {28'h0, fifo_count}, 0);
    check("t6_data0", {24'h0, data_out}, 0);
    repeat (12 * CPB) tick();
    data_out_ready = 1'b1;
    exp_q.push_back(8'h31);
    send_frame(8'h31, 1'b1);
    wait_pops(25);
    tick();

    check("end_q_empty", exp_q.size(), 0);
    check("end_count", {28'h0, fifo_count}, 0);
    check("end_fe_total", fe_seen, 1);
    check("end_ov_total", ov_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Host-facing UART receive stage: deserializes 8N1 frames arriving on serial_in and buffers completed bytes in a small first-word-fall-through FIFO. The CPU's memory-mapped UART RX register consumes bytes through a ready/valid interface. Framing errors and overflows are reported as single-cycle pulses for status CSRs.

Parameters:
CLOCK_FREQ, 125_000_000, clk frequency in Hz
BAUD_RATE, 115_200, line rate in bits/s; CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide, must be >= 4)
FIFO_DEPTH, 8, byte entries, power of two, >= 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
serial_in  input  1  asynchronous UART line, idle high
data_out  output  8  head-of-FIFO byte
data_out_valid  output  1  FIFO non-empty
data_out_ready  input  1  consumer accepts data_out this cycle
fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries
frame_error  output  1  one-cycle pulse: stop bit sampled low
overflow  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset: synchronizer flops = 1, FSM = IDLE, bit/cycle counters = 0, FIFO empty, data_out_valid = 0, fifo_count = 0, frame_error = 0, overflow = 0; data_out = 0 while empty. Reset mid-frame discards the partial byte; reset with FIFO contents discards them.
- serial_in passes through a 2-flop synchronizer; the FSM uses only the synchronized value rx_s.
- Cycle counter cnt counts 0..CYCLES_PER_BIT-1; MID = CYCLES_PER_BIT/2 (integer).
- IDLE: rx_s==0 -> START, cnt=0.
- START: at cnt==MID sample rx_s; 1 -> IDLE (glitch rejected, no pulses); 0 -> DATA, cnt=0, bit_idx=0.
- DATA: at cnt==CYCLES_PER_BIT-1 sample rx_s into shift reg, LSB first (bit_idx 0 = data[0]); cnt=0; after bit_idx 7 -> STOP. Net effect: every bit sampled at its midpoint.
- STOP: at cnt==CYCLES_PER_BIT-1 sample rx_s.
  - 1 and FIFO accepting: push byte -> IDLE.
  - 1 and FIFO not accepting: overflow=1 for one cycle, byte dropped -> IDLE.
  - 0: frame_error=1 for one cycle, byte dropped -> BREAK.
- BREAK: wait for rx_s==1, then IDLE (a held-low line produces exactly one frame_error, not repeated frames).
- FIFO is first-word-fall-through: data_out/data_out_valid reflect the head entry; pop occurs when data_out_valid && data_out_ready. data_out_ready while empty has no effect.
- "Accepting" = count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop in the same cycle (simultaneous push/pop when full succeeds; count unchanged).
- Push latency: data_out_valid rises the cycle after the STOP-sample cycle when the FIFO was empty.
- fifo_count updates the same cycle as push/pop (+1 push only, -1 pop only, unchanged for both or neither).
- Read/write pointers wrap modulo FIFO_DEPTH; full/empty are derived from count, never from pointer equality alone.
- Frame-to-frame: a new start bit may be detected the first cycle back in IDLE; back-to-back frames with a 1-bit stop must be received without loss.

Test Plan:
1. CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000 (5 cycles/bit); send 0x78, ready held 1 -> data_out=0x78 valid exactly one frame later, then popped; fifo_count returns to 0; no pulses.
2. Send 0x78, 0x79, 0x7A, 0x0D back-to-back with ready=0 -> fifo_count=4; then ready=1 -> bytes pop in order 78,79,7A,0D, one per cycle.
3. FIFO_DEPTH=8, ready=0, send 9 frames 0x00..0x08 -> count=8, one overflow pulse at the 9th stop sample, FIFO holds 0x00..0x07. Repeat with ready pulsed in the 9th stop-sample cycle -> 0x08 accepted, no overflow.
4. Send a frame 0x55 with the stop bit driven 0, then hold the line low for 30 bit times -> exactly one frame_error pulse, nothing pushed; after line returns high, 0xA5 is received correctly.
5. Low glitch of 1 cycle (shorter than MID) on an idle line -> FSM returns to IDLE; no push, no pulses.
6. Assert rst for one cycle midway through bit 4 of a frame and with 2 bytes queued -> valid=0, count=0; the next full frame 0x31 is received as 0x31.
